// File: rtl/fb_pixel_sink_pkg.sv
// rtl/fb_pixel_sink_pkg.sv - shared screen geometry, colours and query FSM encodings
package fb_pixel_sink_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int COORD_W     = 11;
  localparam int COLOUR_W    = 3;
  localparam int ADDR_W      = 15;
  localparam int OFFSCREEN_X = 160;

  localparam logic [COLOUR_W-1:0] COL_BLACK   = 3'b000;
  localparam logic [COLOUR_W-1:0] COL_BLUE    = 3'b001;
  localparam logic [COLOUR_W-1:0] COL_GREEN   = 3'b010;
  localparam logic [COLOUR_W-1:0] COL_CYAN    = 3'b011;
  localparam logic [COLOUR_W-1:0] COL_RED     = 3'b100;
  localparam logic [COLOUR_W-1:0] COL_MAGENTA = 3'b101;
  localparam logic [COLOUR_W-1:0] COL_YELLOW  = 3'b110;
  localparam logic [COLOUR_W-1:0] COL_WHITE   = 3'b111;

  typedef enum logic [1:0] {
    Q_IDLE  = 2'd0,
    Q_CHECK = 2'd1,
    Q_READ  = 2'd2,
    Q_RESP  = 2'd3
  } q_state_t;

  function automatic logic in_screen(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return (x < COORD_W'(SCREEN_W)) && (y < COORD_W'(SCREEN_H));
  endfunction

  // y*160 + x as shifts; only meaningful for on-screen coordinates
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - simple dual-port frame RAM, 1-cycle read, write-first on address match
module fb_ram
  import fb_pixel_sink_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [COLOUR_W-1:0] i_wdata,
  input  logic                i_re,
  input  logic [ADDR_W-1:0]   i_raddr,
  output logic [COLOUR_W-1:0] o_rdata
);

  logic [COLOUR_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [COLOUR_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fb_pixel_sink.sv
// rtl/fb_pixel_sink.sv - clips and writes drawer pixels to the frame RAM, serves colour queries
module fb_pixel_sink
  import fb_pixel_sink_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                plot,
  input  logic [COORD_W-1:0]  in_x,
  input  logic [COORD_W-1:0]  in_y,
  input  logic [COLOUR_W-1:0] in_colour,
  input  logic                query_req,
  input  logic [COORD_W-1:0]  query_x,
  input  logic [COORD_W-1:0]  query_y,
  output logic                query_busy,
  output logic                query_valid,
  output logic [COLOUR_W-1:0] query_colour,
  output logic                query_oob,
  output logic [15:0]         write_count,
  output logic [15:0]         clip_count
);

  logic                r_s0_valid, r_s0_in_range;
  logic [COORD_W-1:0]  r_s0_x, r_s0_y;
  logic [COLOUR_W-1:0] r_s0_colour;
  logic                r_s1_valid, r_s1_in_range;
  logic [ADDR_W-1:0]   r_s1_addr;
  logic [COLOUR_W-1:0] r_s1_colour;
  logic [15:0]         r_write_count, r_clip_count;
  logic                w_we;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s0_valid <= plot;
      r_s1_valid <= r_s0_valid;
    end
  end

  always_ff @(posedge clock) begin
    r_s0_x        <= in_x;
    r_s0_y        <= in_y;
    r_s0_colour   <= in_colour;
    r_s0_in_range <= in_screen(in_x, in_y);
    r_s1_addr     <= fb_addr(r_s0_x, r_s0_y);
    r_s1_in_range <= r_s0_in_range;
    r_s1_colour   <= r_s0_colour;
  end

  assign w_we = r_s1_valid && r_s1_in_range;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_write_count <= 16'd0;
      r_clip_count  <= 16'd0;
    end else if (r_s1_valid) begin
      if (r_s1_in_range) begin
        if (r_write_count != 16'hFFFF) r_write_count <= r_write_count + 16'd1;
      end else begin
        if (r_clip_count != 16'hFFFF) r_clip_count <= r_clip_count + 16'd1;
      end
    end
  end

  q_state_t            r_q_state, w_q_next;
  logic [COORD_W-1:0]  r_qx, r_qy;
  logic [COLOUR_W-1:0] r_hold_colour, r_q_colour;
  logic                r_hold_oob, r_q_oob, r_q_valid;
  logic                w_q_in_range, w_rd_en;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [COLOUR_W-1:0] w_rd_data;

  assign w_q_in_range = in_screen(r_qx, r_qy);

  always_comb begin
    w_q_next  = r_q_state;
    w_rd_en   = 1'b0;
    w_rd_addr = fb_addr(r_qx, r_qy);
    case (r_q_state)
      Q_IDLE:  if (query_req) w_q_next = Q_CHECK;
      Q_CHECK: begin
        if (w_q_in_range) begin
          w_rd_en  = 1'b1;
          w_q_next = Q_READ;
        end else begin
          w_q_next = Q_RESP;
        end
      end
      Q_READ:  w_q_next = Q_RESP;
      Q_RESP:  w_q_next = Q_IDLE;
      default: w_q_next = Q_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) r_q_state <= Q_IDLE;
    else         r_q_state <= w_q_next;
  end

  always_ff @(posedge clock) begin
    if (r_q_state == Q_IDLE && query_req) begin
      r_qx <= query_x;
      r_qy <= query_y;
    end
    if (r_q_state == Q_CHECK) begin
      r_hold_colour <= COL_BLACK;
      r_hold_oob    <= !w_q_in_range;
    end
    if (r_q_state == Q_READ) r_hold_colour <= w_rd_data;
  end

  // Response is registered out of RESP, so the pulse lands as the FSM returns to IDLE
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_q_valid  <= 1'b0;
      r_q_colour <= COL_BLACK;
      r_q_oob    <= 1'b0;
    end else begin
      r_q_valid <= (r_q_state == Q_RESP);
      if (r_q_state == Q_RESP) begin
        r_q_colour <= r_hold_colour;
        r_q_oob    <= r_hold_oob;
      end
    end
  end

  fb_ram u_ram (
    .i_clk   (clock),
    .i_we    (w_we),
    .i_waddr (r_s1_addr),
    .i_wdata (r_s1_colour),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  assign query_busy   = (r_q_state != Q_IDLE);
  assign query_valid  = r_q_valid;
  assign query_colour = r_q_colour;
  assign query_oob    = r_q_oob;
  assign write_count  = r_write_count;
  assign clip_count   = r_clip_count;

endmodule

// File: tb/tb_fb_pixel_sink.sv
// tb/tb_fb_pixel_sink.sv - directed-vector bench for fb_pixel_sink
module tb_fb_pixel_sink;

  logic        clock = 1'b0;
  logic        resetn;
  logic        plot;
  logic [10:0] in_x, in_y;
  logic [2:0]  in_colour;
  logic        query_req;
  logic [10:0] query_x, query_y;
  logic        query_busy, query_valid, query_oob;
  logic [2:0]  query_colour;
  logic [15:0] write_count, clip_count;

  int n_vec = 0;
  int n_err = 0;

  fb_pixel_sink dut (
    .clock        (clock),
    .resetn       (resetn),
    .plot         (plot),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_colour    (in_colour),
    .query_req    (query_req),
    .query_x      (query_x),
    .query_y      (query_y),
    .query_busy   (query_busy),
    .query_valid  (query_valid),
    .query_colour (query_colour),
    .query_oob    (query_oob),
    .write_count  (write_count),
    .clip_count   (clip_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put_pixel(input int x, input int y, input logic [2:0] c);
    plot = 1'b1; in_x = 11'(x); in_y = 11'(y); in_colour = c;
    step();
    plot = 1'b0;
  endtask

  task automatic query(input int x, input int y, output logic [2:0] col, output logic oob, output int lat);
    query_req = 1'b1; query_x = 11'(x); query_y = 11'(y);
    step();
    query_req = 1'b0;
    lat = 1;
    while (!query_valid && lat < 12) begin
      step();
      lat++;
    end
    col = query_colour;
    oob = query_oob;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  logic [2:0] col;
  logic       oob;
  int         lat, n_valid, first;

  initial begin
    resetn = 1'b0; plot = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
    query_req = 1'b0; query_x = '0; query_y = '0;
    step();
    step();
    chk("rst_busy",   query_busy,   0);
    chk("rst_valid",  query_valid,  0);
    chk("rst_colour", query_colour, 0);
    chk("rst_oob",    query_oob,    0);
    chk("rst_wcnt",   write_count,  0);
    chk("rst_ccnt",   clip_count,   0);
    resetn = 1'b1;

    // single pixel, query at cycle 3
    put_pixel(5, 3, 3'b100);
    step();
    step();
    query(5, 3, col, oob, lat);
    chk("t1_lat",  lat, 4);
    chk("t1_col",  col, 3'b100);
    chk("t1_oob",  oob, 0);
    chk("t1_wcnt", write_count, 1);

    // full-screen clear
    do_reset();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        plot = 1'b1; in_x = 11'(x); in_y = 11'(y); in_colour = 3'b001;
        step();
      end
    plot = 1'b0;
    step(); step(); step();
    chk("t2_wcnt", write_count, 19200);
    chk("t2_ccnt", clip_count,  0);
    query(0, 0, col, oob, lat);     chk("t2_q00",   col, 3'b001);
    query(159, 119, col, oob, lat); chk("t2_q_end", col, 3'b001);
    query(80, 60, col, oob, lat);   chk("t2_q_mid", col, 3'b001);

    // offscreen plots are clipped; (160,0) would alias address of (0,1)
    put_pixel(160, 0, 3'b111);
    put_pixel(0, 120, 3'b111);
    step(); step(); step();
    chk("t3_ccnt", clip_count,  2);
    chk("t3_wcnt", write_count, 19200);
    query(10, 10, col, oob, lat); chk("t3_q1010", col, 3'b001);
    query(0, 1, col, oob, lat);   chk("t3_q01",   col, 3'b001);

    // offscreen query with query_req held while busy
    query_req = 1'b1; query_x = 11'd200; query_y = 11'd7;
    n_valid = 0; first = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (query_valid) begin
        n_valid++;
        if (first == 0) begin
          first = i;
          col = query_colour;
          oob = query_oob;
        end
      end
      if (i == 3) query_req = 1'b0;
    end
    chk("t4_lat",    first,   3);
    chk("t4_npulse", n_valid, 1);
    chk("t4_oob",    oob,     1);
    chk("t4_col",    col,     3'b000);

    // write-first forwarding on a same-cycle read/write collision
    put_pixel(7, 7, 3'b011);
    step(); step();
    query(7, 7, col, oob, lat); chk("t5_pre", col, 3'b011);
    put_pixel(7, 7, 3'b110);
    query(7, 7, col, oob, lat);
    chk("t5_fwd",     col, 3'b110);
    chk("t5_fwd_lat", lat, 4);

    // reset with a pixel in flight and a query outstanding
    query_req = 1'b1; query_x = 11'd30; query_y = 11'd30;
    step();
    query_req = 1'b0;
    put_pixel(20, 20, 3'b111);
    resetn = 1'b0;
    step();
    chk("t6_busy",  query_busy,  0);
    chk("t6_valid", query_valid, 0);
    chk("t6_wcnt",  write_count, 0);
    chk("t6_ccnt",  clip_count,  0);
    resetn = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (query_valid) n_valid++;
      step();
    end
    chk("t6_nopulse", n_valid, 0);
    query(20, 20, col, oob, lat);
    chk("t6_nowrite", col, 3'b001);
    chk("t6_wcnt_end", write_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
